// File: rtl/modn_counter_pkg.sv
// ----------------------------------------------------------------------------
// modn_counter_pkg
// Shared definitions for the modulo-N counter slice.
//   mode_t      : counting mode encoding (hold / up / down / up-by-step)
//   calc_width  : counter width derived from the modulus, never below one bit
// ----------------------------------------------------------------------------
package modn_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_STEP = 2'b11
    } mode_t;

    // Width needed to hold 0..modulus-1; a modulus of 2 still needs one bit.
    function automatic int calc_width(input int modulus);
        int w;
        w = $clog2(modulus);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/modn_counter_if.sv
// ----------------------------------------------------------------------------
// modn_counter_if
// Control and status bundle of one modulo-N counter.
//   en        : count enable / cascade carry-in          (master -> slave)
//   load      : synchronous parallel load request         (master -> slave)
//   in        : parallel load value                        (master -> slave)
//   mode      : counting mode                              (master -> slave)
//   count     : registered counter value                   (slave -> master)
//   tc        : combinational terminal count / carry-out   (slave -> master)
//   wrap      : one-cycle pulse the cycle after a wrap      (slave -> master)
//   load_err  : one-cycle pulse after a rejected load       (slave -> master)
// ----------------------------------------------------------------------------
interface modn_counter_if
    import modn_counter_pkg::*;
#(
    parameter int MODULUS = 10
);

    localparam int WIDTH = calc_width(MODULUS);

    logic             en;
    logic             load;
    logic [WIDTH-1:0] in;
    mode_t            mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, load, in, mode,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, load, in, mode,
        output count, tc, wrap, load_err
    );

endinterface

// File: rtl/modn_next.sv
// ----------------------------------------------------------------------------
// modn_next
// Purely combinational next-value logic of the modulo-N counter.
//   count      in   current counter value
//   en         in   count enable (only qualifies tc)
//   mode       in   counting mode
//   next_count out  value the counter takes when enabled
//   wrap_cond  out  the enabled step crosses the range boundary
//   tc         out  terminal count / cascade carry-out
// Optional feature: define MODN_COUNTER_SATURATE_EN to clamp at the range
// limits instead of wrapping; wrap_cond is then always 0 and tc flags
// "at the limit for the current mode".
// ----------------------------------------------------------------------------
module modn_next
    import modn_counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int STEP    = 2,
    parameter int WIDTH   = calc_width(MODULUS)
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  mode_t            mode,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_cond,
    output logic             tc
);

    // One extra bit so count+STEP and the modulus itself never overflow.
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH:0] sum;
    logic           at_limit;

    assign sum = {1'b0, count} + STEP_W;

    // at_limit marks the boundary condition of the selected mode; it drives
    // both the wrap/clamp choice and the carry-out.
    always_comb begin
        next_count = count;
        wrap_cond  = 1'b0;
        at_limit   = 1'b0;
        case (mode)
            MODE_UP: begin
                at_limit = (count == MAX_VAL);
`ifdef MODN_COUNTER_SATURATE_EN
                next_count = at_limit ? MAX_VAL : count + WIDTH'(1);
`else
                next_count = at_limit ? '0 : count + WIDTH'(1);
                wrap_cond  = at_limit;
`endif
            end
            MODE_DOWN: begin
                at_limit = (count == '0);
`ifdef MODN_COUNTER_SATURATE_EN
                next_count = at_limit ? '0 : count - WIDTH'(1);
`else
                next_count = at_limit ? MAX_VAL : count - WIDTH'(1);
                wrap_cond  = at_limit;
`endif
            end
            MODE_STEP: begin
`ifdef MODN_COUNTER_SATURATE_EN
                at_limit   = (count == MAX_VAL);
                next_count = (sum >= MOD_W) ? MAX_VAL : WIDTH'(sum);
`else
                at_limit   = (sum >= MOD_W);
                next_count = at_limit ? WIDTH'(sum - MOD_W) : WIDTH'(sum);
                wrap_cond  = at_limit;
`endif
            end
            default: begin
                next_count = count;
            end
        endcase
    end

    assign tc = en & at_limit;

endmodule

// File: rtl/modn_counter.sv
// ----------------------------------------------------------------------------
// modn_counter
// Modulo-N up/down/step counter with parallel load and cascade carry.
//   clk    in   single clock, rising edge
//   reset  in   asynchronous active-high reset
//   bus    slave modport of modn_counter_if (en, load, in, mode in;
//               count, tc, wrap, load_err out)
// Parameters: MODULUS (2..2^16), STEP (1..MODULUS-1). Width is derived.
// Optional feature: MODN_COUNTER_SATURATE_EN selects saturating counting
// (handled inside modn_next).
// ----------------------------------------------------------------------------
module modn_counter
    import modn_counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int STEP    = 2
) (
    input  logic          clk,
    input  logic          reset,
    modn_counter_if.slave bus
);

    localparam int             WIDTH = calc_width(MODULUS);
    localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             load_err_q;
    logic [WIDTH-1:0] next_count;
    logic             wrap_cond;
    logic             tc;
    logic             load_ok;

    modn_next #(
        .MODULUS (MODULUS),
        .STEP    (STEP),
        .WIDTH   (WIDTH)
    ) u_next (
        .count      (count_q),
        .en         (bus.en),
        .mode       (bus.mode),
        .next_count (next_count),
        .wrap_cond  (wrap_cond),
        .tc         (tc)
    );

    // Out-of-range load values are refused so the count never leaves range.
    assign load_ok = ({1'b0, bus.in} < MOD_W);

    // Priority is reset, then load, then enabled counting. Both pulse
    // outputs default low so each lasts exactly one cycle per event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.load) begin
                if (load_ok) begin
                    count_q <= bus.in;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (bus.en) begin
                count_q <= next_count;
                wrap_q  <= wrap_cond;
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_modn_counter.sv
// ----------------------------------------------------------------------------
// tb_modn_counter
// Self-checking bench for modn_counter (MODULUS=10, STEP=2). A driver issues
// one stimulus per cycle and queues the reference model's expected result; a
// monitor pops and compares after every rising edge. A two-stage cascade is
// exercised separately. Honours MODN_COUNTER_SATURATE_EN.
// ----------------------------------------------------------------------------
module tb_modn_counter;
    import modn_counter_pkg::*;

    localparam int TB_MOD  = 10;
    localparam int TB_STEP = 2;

    typedef struct {
        int count;
        bit wrap;
        bit err;
        bit tc;
    } exp_t;

    logic clk;
    logic reset;
    logic cas_en;

    int   checks;
    int   errors;
    int   m_count;
    exp_t exp_q[$];

    modn_counter_if #(.MODULUS(TB_MOD)) dut_if();
    modn_counter_if #(.MODULUS(TB_MOD)) lo_if();
    modn_counter_if #(.MODULUS(TB_MOD)) hi_if();

    modn_counter #(.MODULUS(TB_MOD), .STEP(TB_STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    modn_counter #(.MODULUS(TB_MOD), .STEP(TB_STEP)) u_lo (
        .clk   (clk),
        .reset (reset),
        .bus   (lo_if.slave)
    );

    modn_counter #(.MODULUS(TB_MOD), .STEP(TB_STEP)) u_hi (
        .clk   (clk),
        .reset (reset),
        .bus   (hi_if.slave)
    );

    // The upper digit counts on the lower digit's carry.
    assign lo_if.en = cas_en;
    assign hi_if.en = lo_if.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the counting rules.
    function automatic exp_t modelStep(input bit e, input bit l, input int v, input mode_t md);
        exp_t r;
        int   t;
        r.wrap = 1'b0;
        r.err  = 1'b0;
        if (l) begin
            if (v < TB_MOD) m_count = v;
            else            r.err = 1'b1;
        end else if (e && md != MODE_HOLD) begin
            case (md)
                MODE_UP:   t = m_count + 1;
                MODE_DOWN: t = m_count - 1;
                default:   t = m_count + TB_STEP;
            endcase
`ifdef MODN_COUNTER_SATURATE_EN
            if (t > TB_MOD - 1) t = TB_MOD - 1;
            if (t < 0)          t = 0;
`else
            if (t >= TB_MOD) begin
                t      = t - TB_MOD;
                r.wrap = 1'b1;
            end else if (t < 0) begin
                t      = t + TB_MOD;
                r.wrap = 1'b1;
            end
`endif
            m_count = t;
        end
        r.count = m_count;
        // Inputs persist past the edge, so tc is judged on the new count.
`ifdef MODN_COUNTER_SATURATE_EN
        r.tc = e && (((md == MODE_UP || md == MODE_STEP) && m_count == TB_MOD - 1) ||
                     (md == MODE_DOWN && m_count == 0));
`else
        r.tc = e && ((md == MODE_UP && m_count == TB_MOD - 1) ||
                     (md == MODE_DOWN && m_count == 0) ||
                     (md == MODE_STEP && m_count + TB_STEP >= TB_MOD));
`endif
        return r;
    endfunction

    task automatic applyStimulus(input bit e, input bit l, input int v, input mode_t md);
        @(negedge clk);
        dut_if.en   = e;
        dut_if.load = l;
        dut_if.in   = 4'(v);
        dut_if.mode = md;
        exp_q.push_back(modelStep(e, l, v, md));
    endtask

    // Let the last queued result be compared, then idle the inputs.
    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 5) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (exp_q.size() > 0) begin
            checkOutput("drain_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        dut_if.en   = 1'b0;
        dut_if.load = 1'b0;
    endtask

    // Monitor: every cycle the counter presents a new result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("count",    32'(dut_if.count),    32'(e.count));
                checkOutput("wrap",     32'(dut_if.wrap),     32'(e.wrap));
                checkOutput("load_err", 32'(dut_if.load_err), 32'(e.err));
                checkOutput("tc",       32'(dut_if.tc),       32'(e.tc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v;
        checks = 0;
        errors = 0;
        m_count = 0;
        cas_en = 1'b0;
        dut_if.en = 1'b0; dut_if.load = 1'b0; dut_if.in = '0; dut_if.mode = MODE_HOLD;
        lo_if.load = 1'b0; lo_if.in = '0; lo_if.mode = MODE_UP;
        hi_if.load = 1'b0; hi_if.in = '0; hi_if.mode = MODE_UP;
        reset = 1'b1;

        #1;
        checkOutput("reset_count",    32'(dut_if.count),    0);
        checkOutput("reset_wrap",     32'(dut_if.wrap),     0);
        checkOutput("reset_load_err", 32'(dut_if.load_err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_count = 0;

        $display("[TB] up count from 0");
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, MODE_UP);
        drain();
`ifdef MODN_COUNTER_SATURATE_EN
        checkOutput("up12_final", 32'(dut_if.count), 9);

        $display("[TB] saturation limits");
        applyStimulus(0, 1, 8, MODE_HOLD);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, MODE_UP);
        applyStimulus(0, 1, 8, MODE_HOLD);
        applyStimulus(1, 0, 0, MODE_STEP);
        applyStimulus(0, 1, 1, MODE_HOLD);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, MODE_DOWN);
        drain();
        checkOutput("sat_down_final", 32'(dut_if.count), 0);
`else
        checkOutput("up12_final", 32'(dut_if.count), 2);

        $display("[TB] down and step");
        applyStimulus(0, 1, 0, MODE_HOLD);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, MODE_DOWN);
        applyStimulus(0, 1, 7, MODE_HOLD);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, MODE_STEP);
        drain();
        checkOutput("step_final", 32'(dut_if.count), 3);
`endif

        $display("[TB] load rules");
        applyStimulus(1, 1, 12, MODE_UP);
        applyStimulus(0, 1, 5, MODE_UP);
        applyStimulus(1, 1, 3, MODE_UP);
        drain();
        checkOutput("load_wins", 32'(dut_if.count), 3);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                          int'($urandom_range(0, 15)), mode_t'(2'($urandom_range(0, 3))));
        end
        drain();

        $display("[TB] asynchronous reset");
        applyStimulus(0, 1, 7, MODE_HOLD);
        drain();
        checkOutput("pre_reset_count", 32'(dut_if.count), 7);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_count",    32'(dut_if.count),    0);
        checkOutput("async_reset_wrap",     32'(dut_if.wrap),     0);
        checkOutput("async_reset_load_err", 32'(dut_if.load_err), 0);
        dut_if.load = 1'b1; dut_if.in = 4'd5; dut_if.en = 1'b1; dut_if.mode = MODE_UP;
        @(posedge clk);
        #1;
        checkOutput("reset_ignores_inputs", 32'(dut_if.count), 0);
        @(negedge clk);
        dut_if.load = 1'b0; dut_if.en = 1'b0;
        reset = 1'b0;
        m_count = 0;
        applyStimulus(1, 0, 0, MODE_UP);
`ifndef MODN_COUNTER_SATURATE_EN
        applyStimulus(0, 1, 9, MODE_HOLD);
        applyStimulus(1, 0, 0, MODE_UP);
        drain();
        checkOutput("pending_wrap", 32'(dut_if.wrap), 1);
        reset = 1'b1;
        #1;
        checkOutput("reset_clears_wrap", 32'(dut_if.wrap), 0);
        @(negedge clk);
        reset = 1'b0;
        m_count = 0;
`endif
        drain();

`ifndef MODN_COUNTER_SATURATE_EN
        $display("[TB] two-digit cascade");
        @(negedge clk);
        cas_en = 1'b1;
        v = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            v = (v + 1) % 100;
            checkOutput("cascade_value", 32'(int'(hi_if.count) * 10 + int'(lo_if.count)), 32'(v));
            checkOutput("cascade_lo_wrap", 32'(lo_if.wrap), 32'(v % 10 == 0));
            checkOutput("cascade_hi_wrap", 32'(hi_if.wrap), 32'(v == 0));
        end
        cas_en = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
